// File: rtl/nfc_rng_arb.sv
// nfc_rng_arb: round-robin owner of the shared NFC page-randomizer RNG.
// Grants one requester per page burst. For that burst it derives and loads
// the seed, then paces RNG reads against the owner's ready signal.
// Optional feature macro: NFC_RNG_TIMEOUT_EN enables an 8-bit stall timeout
// in RUN.
module nfc_rng_arb #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*16-1:0]     req_page,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ-1:0]        req_rdy,
    input  logic [31:0]            cfg_seed,
    input  logic [1:0]             cfg_mode,
    output logic [NREQ-1:0]        gnt,
    output logic                   dat_vld,
    output logic [15:0]            dat,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        abort,
    output logic                   rng_en,
    output logic                   rng_rd,
    output logic [31:0]            rng_seed,
    output logic [1:0]             rng_mode,
    input  logic [15:0]            rng_dat
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so that a length of 0 can hold 2^LEN_W words.
    localparam int CW = LEN_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     rr_q;
    logic [OW-1:0]     owner_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       seed_q;
    logic [1:0]        mode_q;

    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [31:0]       pick_seed;
    logic [CW-1:0]     pick_cnt;
    logic              own_req;
    logic              own_rdy;

    logic [15:0]       page_arr [NREQ];
    logic [LEN_W-1:0]  len_arr  [NREQ];

    // Split the flat per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign page_arr[gi] = req_page[16*gi +: 16];
        assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
    end

    assign own_req = req[owner_q];
    assign own_rdy = req_rdy[owner_q];

    // Round-robin pick: first requester after the last winner, rising index order.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!pick_found && req[j[OW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = j[OW-1:0];
            end
        end
    end

    // Seed and word count for the requester being picked. A zero seed would lock the LFSR.
    always_comb begin
        pick_seed = cfg_seed ^ {page_arr[pick_idx], page_arr[pick_idx]};
        if (pick_seed == 32'h0) begin
            pick_seed = 32'h0000_0001;
        end
        if (len_arr[pick_idx] == '0) begin
            pick_cnt = {1'b1, {LEN_W{1'b0}}};
        end else begin
            pick_cnt = {1'b0, len_arr[pick_idx]};
        end
    end

`ifdef NFC_RNG_TIMEOUT_EN
    logic [7:0] stall_q, stall_d;

    // Stall counter: counts RUN cycles without a read; cleared outside RUN and on every read.
    always_comb begin
        stall_d = 8'd0;
        if (state_q == ST_RUN && !rng_rd) begin
            stall_d = stall_q + 8'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 8'd0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    // Burst sequencer: next state and all per-cycle handshake outputs.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        rng_en  = 1'b0;
        rng_rd  = 1'b0;
        done    = '0;
        abort   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_ARM: begin
                gnt[owner_q] = 1'b1;
                rng_en       = 1'b1;
                if (!own_req) begin
                    abort[owner_q] = 1'b1;
                    state_d        = ST_GAP;
                end else if (state_q == ST_LOAD) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt[owner_q] = 1'b1;
                rng_en       = 1'b1;
                if (!own_req) begin
                    abort[owner_q] = 1'b1;
                    state_d        = ST_GAP;
                end else if (own_rdy) begin
                    rng_rd = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        done[owner_q] = 1'b1;
                        state_d       = ST_GAP;
                    end
`ifdef NFC_RNG_TIMEOUT_EN
                end else if (stall_q == 8'hFF) begin
                    abort[owner_q] = 1'b1;
                    state_d        = ST_GAP;
`endif
                end
            end
            ST_GAP: begin
                // rng_en low for this cycle so the next LOAD is a fresh rising edge.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dat_vld  = rng_rd;
    assign dat      = rng_rd ? rng_dat : 16'h0;
    assign rng_seed = seed_q;
    assign rng_mode = mode_q;

    // State, arbitration pointer, and per-burst context latched at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= OW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            seed_q  <= 32'h0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_found) begin
                owner_q <= pick_idx;
                rr_q    <= pick_idx;
                seed_q  <= pick_seed;
                mode_q  <= cfg_mode;
                cnt_q   <= pick_cnt;
            end else if (rng_rd) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nfc_rng_arb.sv
// Self-checking bench for nfc_rng_arb: directed vector table, hand-written
// corner sequences, and a randomized multi-requester run against a
// transaction-level model.
module tb_nfc_rng_arb;

    localparam int NREQ  = 2;
    localparam int LEN_W = 12;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*16-1:0]    req_page;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_rdy;
    logic [31:0]           cfg_seed;
    logic [1:0]            cfg_mode;
    logic [NREQ-1:0]       gnt;
    logic                  dat_vld;
    logic [15:0]           dat;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       abort;
    logic                  rng_en;
    logic                  rng_rd;
    logic [31:0]           rng_seed;
    logic [1:0]            rng_mode;
    logic [15:0]           rng_dat;

    int n_tests = 0;
    int n_fail  = 0;

    nfc_rng_arb #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_page (req_page),
        .req_len  (req_len),
        .req_rdy  (req_rdy),
        .cfg_seed (cfg_seed),
        .cfg_mode (cfg_mode),
        .gnt      (gnt),
        .dat_vld  (dat_vld),
        .dat      (dat),
        .done     (done),
        .abort    (abort),
        .rng_en   (rng_en),
        .rng_rd   (rng_rd),
        .rng_seed (rng_seed),
        .rng_mode (rng_mode),
        .rng_dat  (rng_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running stand-in for the RNG output.
    initial rng_dat = 16'h5A5A;
    always @(posedge clk) begin
        #1;
        rng_dat = 16'($urandom);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},   64'(gnt),      64'h0);
        chk({tag, "_vld"},   64'(dat_vld),  64'h0);
        chk({tag, "_dat"},   64'(dat),      64'h0);
        chk({tag, "_done"},  64'(done),     64'h0);
        chk({tag, "_abort"}, 64'(abort),    64'h0);
        chk({tag, "_en"},    64'(rng_en),   64'h0);
        chk({tag, "_rd"},    64'(rng_rd),   64'h0);
        chk({tag, "_seed"},  64'(rng_seed), 64'h0);
        chk({tag, "_mode"},  64'(rng_mode), 64'h0);
    endtask

    function automatic logic [31:0] exp_seed_of(input logic [31:0] s, input logic [15:0] p);
        logic [31:0] r;
        r = s ^ {p, p};
        if (r == 32'h0) r = 32'h1;
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Directed vector: one requester alone, cycle 0 = first cycle req is high.
    typedef struct {
        int               idx;
        logic [LEN_W-1:0] len;
        logic [15:0]      page;
        logic [31:0]      seed;
        logic [1:0]       mode;
        bit               alt_rdy;   // rdy high only on odd cycles
        logic [31:0]      exp_seed;
        int               exp_words;
        int               exp_first;
        int               exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int n, input vec_t v);
        int words, first, dcyc;
        string t;
        t = $sformatf("vec%0d", n);
        words = 0; first = -1; dcyc = -1;
        req = '0; req_rdy = '0;
        repeat (3) tick();
        req_page[16*v.idx +: 16]       = v.page;
        req_len[LEN_W*v.idx +: LEN_W]  = v.len;
        cfg_seed = v.seed;
        cfg_mode = v.mode;
        req[v.idx] = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            req_rdy[v.idx] = v.alt_rdy ? ((c % 2) == 1) : 1'b1;
            if (c == 2) begin
                cfg_seed = ~v.seed;
                cfg_mode = ~v.mode;
            end
            @(negedge clk);
            if (c == 1) begin
                chk({t, "_gnt"},  64'(gnt),      64'(NREQ'(1) << v.idx));
                chk({t, "_en"},   64'(rng_en),   64'h1);
                chk({t, "_seed"}, 64'(rng_seed), 64'(v.exp_seed));
                chk({t, "_mode"}, 64'(rng_mode), 64'(v.mode));
            end
            if (dat_vld) begin
                words++;
                if (first < 0) first = c;
                if (dat !== rng_dat) chk({t, "_dat"}, 64'(dat), 64'(rng_dat));
                if (!req_rdy[v.idx]) chk({t, "_vld_no_rdy"}, 64'(dat_vld), 64'h0);
            end
            if (abort != '0) chk({t, "_abort"}, 64'(abort), 64'h0);
            if (done != '0) begin
                dcyc = c;
                chk({t, "_done_bit"}, 64'(done), 64'(NREQ'(1) << v.idx));
                chk({t, "_seed_hold"}, 64'(rng_seed), 64'(v.exp_seed));
                break;
            end
            tick();
        end
        chk({t, "_words"}, 64'(words), 64'(v.exp_words));
        chk({t, "_first"}, 64'(first), 64'(v.exp_first));
        chk({t, "_donecyc"}, 64'(dcyc), 64'(v.exp_done));
        tick();
        req = '0;
        @(negedge clk);
        chk({t, "_gap_en"},  64'(rng_en), 64'h0);
        chk({t, "_gap_gnt"}, 64'(gnt),    64'h0);
        tick();
    endtask

    initial begin
        int grants[4];
        int exp_rr[4];
        int ng, words, acyc, naborts;
        logic [NREQ-1:0] prev_g;

        rst = 1'b1; req = '0; req_page = '0; req_len = '0; req_rdy = '0;
        cfg_seed = 32'h0; cfg_mode = 2'b00;
        repeat (3) tick();
        cfg_seed = 32'hDEAD_BEEF; req = '1; req_rdy = '1;
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0; req = '0;

        // ---------------- directed vector table ----------------
        vecs[0] = '{0, 12'd4, 16'h0001, 32'h1234_5678, 2'd1, 1'b0, 32'h1235_5679, 4,    3, 6};
        vecs[1] = '{1, 12'd3, 16'hABCD, 32'h0000_0000, 2'd2, 1'b1, 32'hABCD_ABCD, 3,    3, 7};
        vecs[2] = '{0, 12'd1, 16'hFFFF, 32'hFFFF_FFFF, 2'd3, 1'b0, 32'h0000_0001, 1,    3, 3};
        vecs[3] = '{0, 12'd0, 16'h0001, 32'h0001_0001, 2'd0, 1'b0, 32'h0000_0001, 4096, 3, 4098};
        vecs[4] = '{1, 12'd5, 16'h8000, 32'h0000_0000, 2'd2, 1'b1, 32'h8000_8000, 5,    3, 11};
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // ---------------- round-robin with both requesting ----------------
        do_reset();
        req_len = {12'd2, 12'd2}; req_rdy = '1; req = 2'b11;
        exp_rr = '{0, 1, 0, 1};
        grants = '{-1, -1, -1, -1};
        ng = 0; prev_g = '0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt != '0 && prev_g == '0) begin
                grants[ng] = (gnt == 2'b01) ? 0 : (gnt == 2'b10) ? 1 : -1;
                ng++;
            end
            if (done != '0) begin
                chk("rr_done_owner", 64'(done), 64'(gnt));
                tick();
                @(negedge clk);
                chk("rr_gap_en", 64'(rng_en), 64'h0);
                prev_g = gnt;
            end else begin
                prev_g = gnt;
            end
            tick();
        end
        for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(exp_rr[k]));
        req = '0;
        repeat (6) tick();

        // ---------------- abort after two words ----------------
        do_reset();
        req_len[LEN_W +: LEN_W] = 12'd8; req_rdy = '1; req = 2'b10;
        words = 0;
        for (int c = 0; c < 50 && words < 2; c++) begin
            @(negedge clk);
            if (dat_vld) words++;
            tick();
        end
        req = '0;
        @(negedge clk);
        chk("abort_bit",  64'(abort),   64'h2);
        chk("abort_done", 64'(done),    64'h0);
        chk("abort_vld",  64'(dat_vld), 64'h0);
        tick();
        @(negedge clk);
        chk("abort_gap_en",  64'(rng_en), 64'h0);
        chk("abort_gap_gnt", 64'(gnt),    64'h0);
        tick();

        // ---------------- reset in the middle of RUN ----------------
        req_len[0 +: LEN_W] = 12'd20; req_rdy = '1; req = 2'b01;
        repeat (6) tick();
        @(negedge clk);
        chk("midrst_running", 64'(dat_vld), 64'h1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_zero("midrst");
        tick();
        rst = 1'b0; req = '0;
        repeat (2) tick();

        // ---------------- stalled RUN: timeout or indefinite wait ----------------
        do_reset();
        req_len[0 +: LEN_W] = 12'd4; req_rdy = '0; req = 2'b01;
        acyc = -1; naborts = 0;
`ifdef NFC_RNG_TIMEOUT_EN
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done != '0) chk("tmo_done", 64'(done), 64'h0);
            if (abort != '0) begin
                acyc = c;
                chk("tmo_abort_bit", 64'(abort), 64'h1);
                break;
            end
            tick();
        end
        chk("tmo_abort_cycle", 64'(acyc), 64'd258);
`else
        for (int c = 0; c < 1003; c++) begin
            @(negedge clk);
            if (abort != '0) naborts++;
            tick();
        end
        @(negedge clk);
        chk("notmo_aborts", 64'(naborts), 64'h0);
        chk("notmo_gnt",    64'(gnt),     64'h1);
        chk("notmo_acyc",   64'(acyc),    64'(-1));
`endif
        tick();
        req = '0;
        repeat (3) tick();

        // ---------------- randomized multi-requester run ----------------
        begin
            logic [NREQ-1:0]    pending, prev_req;
            logic [NREQ*16-1:0] prev_page;
            logic [31:0]        prev_seed, cur_seed;
            logic [1:0]         prev_mode;
            logic [NREQ-1:0]    prev_gnt;
            int                 lens[NREQ];
            int                 last_owner, cur_owner, rwords;

            do_reset();
            last_owner = NREQ - 1;
            cur_owner = -1; cur_seed = '0; rwords = 0;
            prev_gnt = '0; prev_req = '0; prev_page = '0; prev_seed = '0; prev_mode = '0;
            for (int r = 0; r < 30; r++) begin
                pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++) begin
                    lens[i] = $urandom_range(1, 6);
                    req_len[LEN_W*i +: LEN_W] = LEN_W'(lens[i]);
                    req_page[16*i +: 16] = 16'($urandom);
                end
                cfg_seed = $urandom;
                for (int c = 0; c < 400 && (pending != '0 || gnt != '0); c++) begin
                    req = pending;
                    req_rdy = NREQ'($urandom);
                    for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) != 0) req_rdy[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) cfg_seed = $urandom;
                    cfg_mode = 2'($urandom);
                    @(negedge clk);
                    if (gnt != '0 && prev_gnt == '0) begin
                        cur_owner = rr_pick(last_owner, prev_req);
                        last_owner = (cur_owner < 0) ? last_owner : cur_owner;
                        cur_seed = exp_seed_of(prev_seed, prev_page[16*last_owner +: 16]);
                        rwords = 0;
                        chk("rnd_gnt",  64'(gnt),      64'(NREQ'(1) << last_owner));
                        chk("rnd_seed", 64'(rng_seed), 64'(cur_seed));
                        chk("rnd_mode", 64'(rng_mode), 64'(prev_mode));
                    end
                    chk("rnd_en", 64'(rng_en), 64'(gnt != '0));
                    if (gnt != '0 && rng_seed !== cur_seed) chk("rnd_seed_hold", 64'(rng_seed), 64'(cur_seed));
                    if (dat_vld) begin
                        rwords++;
                        if (dat !== rng_dat) chk("rnd_dat", 64'(dat), 64'(rng_dat));
                        if (!req_rdy[last_owner]) chk("rnd_vld_rdy", 64'(req_rdy[last_owner]), 64'h1);
                    end
                    if (abort != '0) chk("rnd_abort", 64'(abort), 64'h0);
                    if (done != '0) begin
                        chk("rnd_done_bit", 64'(done),   64'(NREQ'(1) << last_owner));
                        chk("rnd_words",    64'(rwords), 64'(lens[last_owner]));
                        pending = pending & ~done;
                    end
                    prev_gnt  = gnt;
                    prev_req  = req;
                    prev_page = req_page;
                    prev_seed = cfg_seed;
                    prev_mode = cfg_mode;
                    tick();
                end
                chk("rnd_round_drained", 64'(pending), 64'h0);
                req = '0;
                tick();
                prev_req = '0;
                prev_gnt = '0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
